// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU, driving the 8x16 register file.
// Accumulator A is register 0; results are written back one cycle after the operand read.
module cpu_control_unit #(
    parameter logic [15:0] PC_RESET      = 16'h0000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    output logic [15:0] instr_addr,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    output logic [2:0]  reg_sel_out,
    output logic        reg_oe,
    input  logic [15:0] reg_rdata,
    input  logic [15:0] acc_in,
    output logic [2:0]  reg_sel_in,
    output logic        reg_we,
    output logic [15:0] reg_wdata,
    output logic        flag_z,
    output logic        flag_c,
    output logic        halted,
    output logic        fault,
    output logic [2:0]  dbg_state
);

    // Fetch handshake: instr_req is high for every FETCH cycle; a cycle with
    // instr_req=1 and instr_valid=1 accepts instr_data at the rising edge.
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_wdata;
    logic [2:0]  r_sel_out;
    logic [2:0]  r_sel_in;
    logic        r_z;
    logic        r_c;
    logic        r_fault;
    logic [7:0]  r_tcnt;

    logic [3:0]  w_op;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs;
    logic [7:0]  w_imm;
    logic [16:0] w_sum;
    logic [15:0] w_res;
    logic        w_c;

    assign w_op  = r_ir[15:12];
    assign w_rd  = r_ir[11:9];
    assign w_rs  = r_ir[8:6];
    assign w_imm = r_ir[7:0];

    // SUB runs as A + ~rs + 1 so the carry out reads as "no borrow".
    always_comb begin
        w_sum = 17'd0;
        w_res = 16'd0;
        w_c   = 1'b0;
        case (w_op)
            4'h2: w_res = reg_rdata;
            4'h3: begin
                w_sum = {1'b0, acc_in} + {1'b0, reg_rdata};
                w_res = w_sum[15:0];
                w_c   = w_sum[16];
            end
            4'h4: begin
                w_sum = {1'b0, acc_in} + {1'b0, ~reg_rdata} + 17'd1;
                w_res = w_sum[15:0];
                w_c   = w_sum[16];
            end
            4'h5: w_res = acc_in & reg_rdata;
            4'h6: w_res = acc_in | reg_rdata;
            4'h7: w_res = acc_in ^ reg_rdata;
            default: w_res = reg_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: w_next = S_FETCH;
            S_FETCH: begin
                if (instr_valid)
                    w_next = S_DECODE;
                else if (r_tcnt == TO_LAST)
                    w_next = S_HALT;
            end
            S_DECODE: begin
                case (w_op)
                    4'h1:                                    w_next = S_WRITE;
                    4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:      w_next = S_READ;
                    4'hF:                                    w_next = S_HALT;
                    default:                                 w_next = S_FETCH;
                endcase
            end
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RESET;
            r_pc      <= PC_RESET;
            r_ir      <= 16'd0;
            r_wdata   <= 16'd0;
            r_sel_out <= 3'd0;
            r_sel_in  <= 3'd0;
            r_z       <= 1'b0;
            r_c       <= 1'b0;
            r_fault   <= 1'b0;
            r_tcnt    <= 8'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    if (instr_valid) begin
                        r_ir   <= instr_data;
                        r_pc   <= r_pc + 16'd1;
                        r_tcnt <= 8'd0;
                    end else if (r_tcnt == TO_LAST) begin
                        r_fault <= 1'b1;
                        r_tcnt  <= 8'd0;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    // Jump targets replace the already-incremented pc.
                    case (w_op)
                        4'h1: begin
                            r_sel_in <= w_rd;
                            r_wdata  <= {8'h00, w_imm};
                        end
                        4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: r_sel_out <= w_rs;
                        4'h8: r_pc <= {8'h00, w_imm};
                        4'h9: if (r_z) r_pc <= {8'h00, w_imm};
                        default: ;
                    endcase
                end
                S_READ: begin
                    r_sel_in <= w_rd;
                    r_wdata  <= w_res;
                    r_z      <= (w_res == 16'd0);
                    r_c      <= w_c;
                end
                default: ;
            endcase
        end
    end

    assign instr_req   = (r_state == S_FETCH);
    assign instr_addr  = r_pc;
    assign reg_sel_out = r_sel_out;
    assign reg_oe      = (r_state == S_READ);
    assign reg_sel_in  = r_sel_in;
    assign reg_we      = (r_state == S_WRITE);
    assign reg_wdata   = r_wdata;
    assign flag_z      = r_z;
    assign flag_c      = r_c;
    assign halted      = (r_state == S_HALT);
    assign fault       = r_fault;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed program with a register-file model and a write scoreboard.
// A second instance with PC_RESET=FFFF runs in lockstep to observe pc wrap-around.
module tb_cpu_control_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        instr_valid = 1'b0;
    logic [15:0] instr_data = 16'd0;
    logic        instr_req;
    logic [15:0] instr_addr;
    logic [2:0]  reg_sel_out;
    logic        reg_oe;
    logic [15:0] reg_rdata;
    logic [15:0] acc_in;
    logic [2:0]  reg_sel_in;
    logic        reg_we;
    logic [15:0] reg_wdata;
    logic        flag_z;
    logic        flag_c;
    logic        halted;
    logic        fault;
    logic [2:0]  dbg_state;

    logic        u2_req;
    logic [15:0] u2_addr;
    logic [2:0]  u2_sel_out;
    logic        u2_oe;
    logic [2:0]  u2_sel_in;
    logic        u2_we;
    logic [15:0] u2_wdata;
    logic        u2_z;
    logic        u2_c;
    logic        u2_halted;
    logic        u2_fault;
    logic [2:0]  u2_dbg;

    logic [15:0] rf [8];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_addr = 3'd0;
    logic [15:0] pl_data = 16'd0;

    assign reg_rdata = rf[reg_sel_out];
    assign acc_in    = rf[0];

    always @(posedge clk) begin
        if (pl_en)
            rf[pl_addr] <= pl_data;
        else if (reg_we)
            rf[reg_sel_in] <= reg_wdata;
    end

    cpu_control_unit #(.PC_RESET(16'h0000), .FETCH_TIMEOUT(255)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .reg_sel_out(reg_sel_out), .reg_oe(reg_oe), .reg_rdata(reg_rdata),
        .acc_in(acc_in),
        .reg_sel_in(reg_sel_in), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .fault(fault),
        .dbg_state(dbg_state)
    );

    cpu_control_unit #(.PC_RESET(16'hFFFF), .FETCH_TIMEOUT(255)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .instr_req(u2_req), .instr_addr(u2_addr),
        .instr_valid(instr_valid), .instr_data(instr_data),
        .reg_sel_out(u2_sel_out), .reg_oe(u2_oe), .reg_rdata(reg_rdata),
        .acc_in(acc_in),
        .reg_sel_in(u2_sel_in), .reg_we(u2_we), .reg_wdata(u2_wdata),
        .flag_z(u2_z), .flag_c(u2_c), .halted(u2_halted), .fault(u2_fault),
        .dbg_state(u2_dbg)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [18:0] exp_q[$];
    logic [18:0] exp_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every reg_we pulse must match the oldest expected {rd, data}.
    always @(negedge clk) begin
        if (rst_n && reg_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: sel=%0d data=%h with nothing expected", reg_sel_in, reg_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                check("write", {13'd0, reg_sel_in, reg_wdata}, {13'd0, exp_w});
            end
        end
    end

    task automatic wait_issue(input int spacing);
        int n = 0;
        int oe = 0;
        while (!instr_req && n < 400) begin
            if (reg_oe) oe++;
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, instr_req}, 32'd1);
        if (spacing >= 0) begin
            check("issue_spacing", n + 1, spacing);
            check("oe_cycles", oe, (spacing == 4) ? 1 : 0);
        end
    endtask

    task automatic issue(input logic [15:0] addr, input logic [15:0] instr);
        check("instr_addr", {16'd0, instr_addr}, {16'd0, addr});
        instr_valid = 1'b1;
        instr_data  = instr;
        @(negedge clk);
        instr_valid = 1'b0;
        instr_data  = 16'd0;
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic check_flags(input string name, input logic z, input logic c);
        check({name, "_z"}, {31'd0, flag_z}, {31'd0, z});
        check({name, "_c"}, {31'd0, flag_c}, {31'd0, c});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset while a write is in flight
        wait_issue(-1);
        issue(16'h0000, 16'h1A77);
        n = 0;
        while (!reg_we && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("we_before_reset", {31'd0, reg_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_we", {31'd0, reg_we}, 32'd0);
        check("rst_addr", {16'd0, instr_addr}, 32'h0000);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_req", {31'd0, instr_req}, 32'd0);
        @(negedge clk);
        check("rst_sel_in", {29'd0, reg_sel_in}, 32'd0);
        check("rst_wdata", {16'd0, reg_wdata}, 32'd0);
        check("rst_oe", {31'd0, reg_oe}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check_flags("rst", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap instance starts at FFFF and rolls to 0000
        wait_issue(-1);
        check("wrap_start", {16'd0, u2_addr}, 32'hFFFF);
        issue(16'h0000, 16'h0000);
        wait_issue(2);
        check("wrap_next", {16'd0, u2_addr}, 32'h0000);

        exp_q.push_back({3'd3, 16'h005A});
        issue(16'h0001, 16'h165A);
        wait_issue(3);

        preload(3'd0, 16'hFFFF);
        preload(3'd1, 16'h0001);
        exp_q.push_back({3'd2, 16'h0000});
        issue(16'h0002, 16'h3440);
        wait_issue(4);
        check_flags("add_ovf", 1'b1, 1'b1);

        preload(3'd0, 16'h0003);
        preload(3'd4, 16'h0005);
        exp_q.push_back({3'd0, 16'hFFFE});
        issue(16'h0003, 16'h4100);
        wait_issue(4);
        check_flags("sub_borrow", 1'b0, 1'b0);

        issue(16'h0004, 16'h9010);
        wait_issue(2);

        preload(3'd0, 16'h00F0);
        preload(3'd5, 16'h00F0);
        exp_q.push_back({3'd6, 16'h0000});
        issue(16'h0005, 16'h7D40);
        wait_issue(4);
        check_flags("xor_zero", 1'b1, 1'b0);

        issue(16'h0006, 16'h9040);
        wait_issue(2);

        exp_q.push_back({3'd7, 16'h00F1});
        issue(16'h0040, 16'h6E40);
        wait_issue(4);
        check_flags("or", 1'b0, 1'b0);

        exp_q.push_back({3'd2, 16'h005A});
        issue(16'h0041, 16'h24C0);
        wait_issue(4);

        exp_q.push_back({3'd5, 16'h00EF});
        issue(16'h0042, 16'h4A40);
        wait_issue(4);
        check_flags("sub_noborrow", 1'b0, 1'b1);

        exp_q.push_back({3'd0, 16'h00FF});
        issue(16'h0043, 16'h10FF);
        wait_issue(3);
        check_flags("ldi_keeps", 1'b0, 1'b1);

        exp_q.push_back({3'd1, 16'h00F1});
        issue(16'h0044, 16'h53C0);
        wait_issue(4);
        check_flags("and", 1'b0, 1'b0);

        issue(16'h0045, 16'hB000);
        wait_issue(2);
        issue(16'h0046, 16'h8020);
        wait_issue(2);

        // Valid arriving on the last permitted FETCH cycle is accepted
        repeat (254) @(negedge clk);
        check("late_not_halted", {31'd0, halted}, 32'd0);
        issue(16'h0020, 16'h0000);
        wait_issue(2);

        // No valid at all: fault-halt after the timeout
        repeat (254) @(negedge clk);
        check("to_last_req", {31'd0, instr_req}, 32'd1);
        @(negedge clk);
        check("to_halted", {31'd0, halted}, 32'd1);
        check("to_fault", {31'd0, fault}, 32'd1);
        check("to_req", {31'd0, instr_req}, 32'd0);
        instr_valid = 1'b1;
        repeat (3) @(negedge clk);
        instr_valid = 1'b0;
        check("to_stays_halted", {31'd0, halted}, 32'd1);

        rst_n = 1'b0;
        #1;
        check("rst2_fault", {31'd0, fault}, 32'd0);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // HLT opcode halts without fault
        wait_issue(-1);
        issue(16'h0000, 16'h0000);
        wait_issue(2);
        issue(16'h0001, 16'hF000);
        @(negedge clk);
        check("hlt_halted", {31'd0, halted}, 32'd1);
        check("hlt_fault", {31'd0, fault}, 32'd0);
        check("hlt_req", {31'd0, instr_req}, 32'd0);

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
